// File: rtl/mem_access_stage_if.sv
// Data-memory port of the MEM stage: req/ack handshake plus write lanes and read word.
interface mem_access_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: ALU passthrough, load/store req/ack transaction with lane
// steering, sign/zero extension, misalignment check and bus timeout.
module mem_access_stage #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ExValid,
   input  logic [31:0]        ExAluResult,
   input  logic [31:0]        ExStoreData,
   input  logic               ExMemRead,
   input  logic               ExMemWrite,
   input  logic [2:0]         ExFunct3,
   input  logic               ExRegWrite,
   input  logic [4:0]         ExRd,
   output logic [31:0]        MemResult,
   output logic               MemRegWrite,
   output logic [4:0]         MemRd,
   output logic               MemStall,
   output logic               MemMisalign,
   output logic               MemBusErr,
   mem_access_stage_if.master dmem
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      addrReg;
   logic [31:0]      wdataReg;
   logic [3:0]       wstrbReg;
   logic [2:0]       funct3Reg;
   logic             regWriteReg;
   logic [4:0]       rdReg;
   logic             weReg;
   logic             reqReg;
   logic [31:0]      resultReg;
   logic             busErrReg;

   logic             isMemOp;
   logic             isLegal;
   logic [31:0]      wdataNext;
   logic [3:0]       wstrbNext;

   // Pick the addressed byte/half out of the read word and extend it.
   function automatic logic [31:0] extractLoad(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  f3);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(word >> {lane, 3'b000});
      h = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b100:  return {24'd0, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b101:  return {16'd0, h};
         default: return word;
      endcase
   endfunction

   // Decode legality of the EX/MEM access and steer store data onto byte lanes.
   always_comb begin
      isMemOp   = ExValid & (ExMemRead | ExMemWrite);
      isLegal   = 1'b0;
      wdataNext = ExStoreData;
      wstrbNext = 4'b0000;
      if (ExMemRead & ~ExMemWrite) begin
         case (ExFunct3)
            3'b000, 3'b100: isLegal = 1'b1;
            3'b001, 3'b101: isLegal = ~ExAluResult[0];
            3'b010:         isLegal = (ExAluResult[1:0] == 2'b00);
            default:        isLegal = 1'b0;
         endcase
      end else if (ExMemWrite & ~ExMemRead) begin
         case (ExFunct3)
            3'b000: begin
               isLegal   = 1'b1;
               wdataNext = {4{ExStoreData[7:0]}};
               wstrbNext = 4'b0001 << ExAluResult[1:0];
            end
            3'b001: begin
               isLegal   = ~ExAluResult[0];
               wdataNext = {2{ExStoreData[15:0]}};
               wstrbNext = 4'b0011 << ExAluResult[1:0];
            end
            3'b010: begin
               isLegal   = (ExAluResult[1:0] == 2'b00);
               wstrbNext = 4'b1111;
            end
            default: isLegal = 1'b0;
         endcase
      end
   end

   // Transaction FSM: capture in IDLE, wait for ack or timeout in BUSY, present in DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         addrReg     <= '0;
         wdataReg    <= '0;
         wstrbReg    <= '0;
         funct3Reg   <= '0;
         regWriteReg <= 1'b0;
         rdReg       <= '0;
         weReg       <= 1'b0;
         reqReg      <= 1'b0;
         resultReg   <= '0;
         busErrReg   <= 1'b0;
      end else begin
         busErrReg <= 1'b0;
         case (state)
            IDLE: begin
               if (isMemOp && isLegal) begin
                  addrReg     <= ExAluResult;
                  wdataReg    <= wdataNext;
                  wstrbReg    <= wstrbNext;
                  funct3Reg   <= ExFunct3;
                  regWriteReg <= ExRegWrite & ExMemRead;
                  rdReg       <= ExRd;
                  weReg       <= ExMemWrite;
                  reqReg      <= 1'b1;
                  resultReg   <= '0;
                  cnt         <= '0;
                  state       <= BUSY;
               end
            end
            BUSY: begin
               if (dmem.dmem_ack) begin
                  resultReg <= weReg ? 32'd0
                                     : extractLoad(dmem.dmem_rdata, addrReg[1:0], funct3Reg);
                  reqReg    <= 1'b0;
                  weReg     <= 1'b0;
                  state     <= DONE;
               end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  reqReg      <= 1'b0;
                  weReg       <= 1'b0;
                  regWriteReg <= 1'b0;
                  busErrReg   <= 1'b1;
                  state       <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // MEM/WB-facing outputs: passthrough in IDLE, captured result in DONE; forced low in reset.
   always_comb begin
      MemResult   = ExAluResult;
      MemRegWrite = 1'b0;
      MemRd       = ExRd;
      MemStall    = 1'b0;
      MemMisalign = 1'b0;
      case (state)
         IDLE: begin
            MemRegWrite = ExValid & ExRegWrite & ~isMemOp;
            MemStall    = isMemOp & isLegal;
            MemMisalign = isMemOp & ~isLegal;
         end
         BUSY: begin
            MemResult = resultReg;
            MemRd     = rdReg;
            MemStall  = 1'b1;
         end
         DONE: begin
            MemResult   = resultReg;
            MemRegWrite = regWriteReg;
            MemRd       = rdReg;
         end
         default: begin
            MemResult = '0;
            MemRd     = '0;
         end
      endcase
      if (!rst) begin
         MemResult   = '0;
         MemRegWrite = 1'b0;
         MemRd       = '0;
         MemStall    = 1'b0;
         MemMisalign = 1'b0;
      end
   end

   assign MemBusErr       = busErrReg;
   assign dmem.dmem_req   = reqReg;
   assign dmem.dmem_we    = weReg;
   assign dmem.dmem_addr  = {addrReg[31:2], 2'b00};
   assign dmem.dmem_wdata = wdataReg;
   assign dmem.dmem_wstrb = wstrbReg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage with a behavioural access model.
module tb_mem_access_stage;
   localparam int unsigned TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ExValid = 1'b0;
   logic [31:0] ExAluResult = '0;
   logic [31:0] ExStoreData = '0;
   logic        ExMemRead = 1'b0;
   logic        ExMemWrite = 1'b0;
   logic [2:0]  ExFunct3 = '0;
   logic        ExRegWrite = 1'b0;
   logic [4:0]  ExRd = '0;
   logic [31:0] MemResult;
   logic        MemRegWrite;
   logic [4:0]  MemRd;
   logic        MemStall;
   logic        MemMisalign;
   logic        MemBusErr;

   int tests = 0;
   int fails = 0;

   mem_access_stage_if dmem();

   mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk(clk), .rst(rst),
      .ExValid(ExValid), .ExAluResult(ExAluResult), .ExStoreData(ExStoreData),
      .ExMemRead(ExMemRead), .ExMemWrite(ExMemWrite), .ExFunct3(ExFunct3),
      .ExRegWrite(ExRegWrite), .ExRd(ExRd),
      .MemResult(MemResult), .MemRegWrite(MemRegWrite), .MemRd(MemRd),
      .MemStall(MemStall), .MemMisalign(MemMisalign), .MemBusErr(MemBusErr),
      .dmem(dmem)
   );

   always #5 clk = ~clk;

   // Access is legal when exactly one of read/write is set, the size code exists for
   // that direction, and the address is a multiple of the access size.
   function automatic bit model_legal(input bit rd_, input bit wr_, input logic [2:0] f3,
                                      input logic [31:0] a);
      int unsigned n;
      if (rd_ == wr_) return 1'b0;
      if (f3[1:0] == 2'b11) return 1'b0;
      if (wr_ && f3[2]) return 1'b0;
      n = 32'd1 << f3[1:0];
      return (a % n) == 0;
   endfunction

   // Load value: take size-wide field at the byte offset, extend by arithmetic.
   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] w);
      longint unsigned bits, span, v;
      bits = 64'd8 << f3[1:0];
      span = 64'd1 << bits;
      v = (64'(w) >> (8 * (a % 4))) % span;
      if (!f3[2] && bits < 32 && v >= span / 2) v = v + (64'h1_0000_0000 - span);
      return 32'(v);
   endfunction

   function automatic logic [2:0] pick_f3(input bit wr);
      logic [2:0] loads [5];
      loads = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      if (wr) return 3'($urandom_range(0, 2));
      return loads[$urandom_range(0, 4)];
   endfunction

   task automatic idle_inputs();
      ExValid = 1'b0; ExMemRead = 1'b0; ExMemWrite = 1'b0; ExRegWrite = 1'b0;
   endtask

   // One full memory transaction; ackAt = BUSY cycle carrying ack (0 = never).
   task automatic run_mem(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] rd, input bit rw,
                          input logic [31:0] rdata, input int ackAt);
      int unsigned n;
      int          off;
      int          k;
      bit          done;
      bit          timedOut;
      bit          expRw;
      logic [31:0] expWd;
      logic [3:0]  expStrb;
      logic [31:0] expRes;
      n = 32'd1 << f3[1:0];
      off = int'(addr % 4);
      for (int i = 0; i < 4; i++) begin
         expWd[8*i +: 8] = 8'(sdata >> (8 * (i % n)));
         expStrb[i] = wr && (i >= off) && (i < off + int'(n));
      end
      expRes = wr ? 32'd0 : model_load(f3, addr, rdata);
      timedOut = (ackAt == 0);
      expRw = !wr && rw && !timedOut;

      ExValid = 1'b1; ExMemRead = !wr; ExMemWrite = wr; ExFunct3 = f3;
      ExAluResult = addr; ExStoreData = sdata; ExRd = rd; ExRegWrite = rw;
      @(negedge clk);
      tests++;
      if (MemStall !== 1'b1 || MemRegWrite !== 1'b0 || dmem.dmem_req !== 1'b0 || MemMisalign !== 1'b0) begin
         fails++;
         $display("FAIL issue addr=%h: stall=%b regwrite=%b req=%b misalign=%b, required 1 0 0 0",
                  addr, MemStall, MemRegWrite, dmem.dmem_req, MemMisalign);
      end
      @(posedge clk); #1;

      k = 0; done = 1'b0;
      while (!done) begin
         k++;
         dmem.dmem_ack = (k == ackAt);
         dmem.dmem_rdata = (k == ackAt) ? rdata : $urandom;
         @(negedge clk);
         tests++;
         if (dmem.dmem_req !== 1'b1 || MemStall !== 1'b1 || MemBusErr !== 1'b0 ||
             dmem.dmem_addr !== (addr & 32'hFFFF_FFFC) || dmem.dmem_we !== wr ||
             dmem.dmem_wstrb !== expStrb || (wr && dmem.dmem_wdata !== expWd)) begin
            fails++;
            $display("FAIL busy cycle %0d: req=%b stall=%b err=%b addr=%h we=%b strb=%b wdata=%h, required 1 1 0 %h %b %b %h",
                     k, dmem.dmem_req, MemStall, MemBusErr, dmem.dmem_addr, dmem.dmem_we,
                     dmem.dmem_wstrb, dmem.dmem_wdata, addr & 32'hFFFF_FFFC, wr, expStrb, expWd);
         end
         if (k == ackAt || k == int'(TIMEOUT)) done = 1'b1;
         @(posedge clk); #1;
         dmem.dmem_ack = 1'b0;
      end

      // DONE: present a different access upstream and a stray ack; both must be ignored.
      ExValid = 1'b1; ExMemRead = 1'b1; ExMemWrite = 1'b0; ExFunct3 = 3'b010;
      ExAluResult = $urandom & 32'hFFFF_FFFC; ExRegWrite = 1'b1; ExRd = rd ^ 5'd1;
      dmem.dmem_ack = 1'b1;
      @(negedge clk);
      tests++;
      if (MemStall !== 1'b0 || dmem.dmem_req !== 1'b0 || MemRegWrite !== expRw || MemRd !== rd ||
          MemBusErr !== timedOut || MemMisalign !== 1'b0 || (!timedOut && MemResult !== expRes)) begin
         fails++;
         $display("FAIL done addr=%h: stall=%b req=%b rw=%b rd=%0d err=%b mis=%b result=%h, required 0 0 %b %0d %b 0 %h",
                  addr, MemStall, dmem.dmem_req, MemRegWrite, MemRd, MemBusErr, MemMisalign,
                  MemResult, expRw, rd, timedOut, expRes);
      end
      @(posedge clk); #1;
      dmem.dmem_ack = 1'b0;
      idle_inputs();
      @(negedge clk);
      tests++;
      if (MemStall !== 1'b0 || dmem.dmem_req !== 1'b0 || MemBusErr !== 1'b0) begin
         fails++;
         $display("FAIL after done: stall=%b req=%b err=%b, required 0 0 0", MemStall, dmem.dmem_req, MemBusErr);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      dmem.dmem_ack = 1'b0; dmem.dmem_rdata = '0;
      #1 rst = 1'b0;
      @(negedge clk);
      tests++;
      if (dmem.dmem_req !== 1'b0 || dmem.dmem_we !== 1'b0 || dmem.dmem_wstrb !== 4'b0000 ||
          MemStall !== 1'b0 || MemMisalign !== 1'b0 || MemBusErr !== 1'b0 || MemRegWrite !== 1'b0) begin
         fails++;
         $display("FAIL reset: req=%b we=%b strb=%b stall=%b mis=%b err=%b rw=%b, required all 0",
                  dmem.dmem_req, dmem.dmem_we, dmem.dmem_wstrb, MemStall, MemMisalign, MemBusErr, MemRegWrite);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_alu_passthrough();
      ExValid = 1'b1; ExRegWrite = 1'b1; ExRd = 5'd5; ExAluResult = 32'h1234;
      ExMemRead = 1'b0; ExMemWrite = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) begin
            ExValid = 1'($urandom); ExRegWrite = 1'($urandom); ExRd = 5'($urandom);
            ExAluResult = $urandom;
            ExMemRead = ExValid ? 1'b0 : 1'($urandom);
            ExMemWrite = ExValid ? 1'b0 : 1'($urandom);
         end
         @(negedge clk);
         tests++;
         if (MemResult !== ExAluResult || MemRegWrite !== (ExValid & ExRegWrite) || MemRd !== ExRd ||
             MemStall !== 1'b0 || dmem.dmem_req !== 1'b0 || MemMisalign !== 1'b0) begin
            fails++;
            $display("FAIL alu %0d: result=%h rw=%b rd=%0d stall=%b req=%b mis=%b, required %h %b %0d 0 0 0",
                     i, MemResult, MemRegWrite, MemRd, MemStall, dmem.dmem_req, MemMisalign,
                     ExAluResult, ExValid & ExRegWrite, ExRd);
         end
         @(posedge clk); #1;
      end
      idle_inputs();
   endtask

   task automatic check_misalign(input bit rd_, input bit wr_, input logic [2:0] f3,
                                 input logic [31:0] a);
      ExValid = 1'b1; ExMemRead = rd_; ExMemWrite = wr_; ExFunct3 = f3;
      ExAluResult = a; ExRegWrite = 1'b1; ExRd = 5'($urandom); ExStoreData = $urandom;
      @(negedge clk);
      tests++;
      if (MemMisalign !== 1'b1 || MemStall !== 1'b0 || MemRegWrite !== 1'b0 || dmem.dmem_req !== 1'b0) begin
         fails++;
         $display("FAIL misalign r=%b w=%b f3=%b addr=%h: mis=%b stall=%b rw=%b req=%b, required 1 0 0 0",
                  rd_, wr_, f3, a, MemMisalign, MemStall, MemRegWrite, dmem.dmem_req);
      end
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      tests++;
      if (MemMisalign !== 1'b0 || MemStall !== 1'b0 || dmem.dmem_req !== 1'b0) begin
         fails++;
         $display("FAIL misalign after: mis=%b stall=%b req=%b, required 0 0 0", MemMisalign, MemStall, dmem.dmem_req);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_misalign();
      bit          r;
      logic [2:0]  f3;
      logic [31:0] a;
      int          found;
      check_misalign(1'b1, 1'b0, 3'b010, 32'h6);
      check_misalign(1'b1, 1'b0, 3'b011, 32'h0);
      check_misalign(1'b1, 1'b1, 3'b000, 32'h0);
      check_misalign(1'b0, 1'b1, 3'b100, 32'h0);
      check_misalign(1'b0, 1'b1, 3'b001, 32'h13);
      found = 0;
      for (int i = 0; i < 200 && found < 6; i++) begin
         r = 1'($urandom); f3 = 3'($urandom); a = $urandom;
         if (!model_legal(r, !r, f3, a)) begin
            check_misalign(r, !r, f3, a);
            found++;
         end
      end
   endtask

   task automatic test_directed_mem();
      run_mem(1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 1'b1, 32'h80AABBCC, 2);
      run_mem(1'b0, 3'b100, 32'h103, 32'h0, 5'd7, 1'b1, 32'h80AABBCC, 2);
      run_mem(1'b1, 3'b001, 32'h22, 32'hDEAD1234, 5'd0, 1'b0, 32'h0, 1);
   endtask

   task automatic test_random_mem();
      bit          wr;
      logic [2:0]  f3;
      logic [31:0] a;
      int unsigned n;
      for (int i = 0; i < 20; i++) begin
         wr = 1'($urandom);
         f3 = pick_f3(wr);
         n = 32'd1 << f3[1:0];
         a = $urandom & ~(n - 1);
         run_mem(wr, f3, a, $urandom, 5'($urandom), 1'($urandom), $urandom,
                 int'($urandom_range(1, TIMEOUT)));
      end
   endtask

   task automatic test_timeout();
      run_mem(1'b0, 3'b010, 32'h400, 32'h0, 5'd9, 1'b1, 32'h0, 0);
      run_mem(1'b0, 3'b001, 32'h402, 32'h0, 5'd10, 1'b1, 32'hCAFE8001, int'(TIMEOUT));
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++)
         run_mem(1'b0, 3'b010, 32'h100 + 32'(4 * i), 32'h0, 5'(i + 1), 1'b1, $urandom, 1);
   endtask

   task automatic test_reset_mid();
      logic [31:0] alu;
      ExValid = 1'b1; ExMemRead = 1'b1; ExMemWrite = 1'b0; ExFunct3 = 3'b010;
      ExAluResult = 32'h40; ExRegWrite = 1'b1; ExRd = 5'd12;
      @(posedge clk); #1;
      #2 rst = 1'b0;
      #1;
      tests++;
      if (dmem.dmem_req !== 1'b0 || MemStall !== 1'b0 || MemRegWrite !== 1'b0 || MemResult !== 32'd0 ||
          MemRd !== 5'd0 || MemBusErr !== 1'b0 || MemMisalign !== 1'b0 || dmem.dmem_we !== 1'b0) begin
         fails++;
         $display("FAIL reset mid: req=%b stall=%b rw=%b result=%h rd=%0d err=%b mis=%b we=%b, required all 0",
                  dmem.dmem_req, MemStall, MemRegWrite, MemResult, MemRd, MemBusErr, MemMisalign, dmem.dmem_we);
      end
      @(negedge clk);
      rst = 1'b1;
      idle_inputs();
      @(posedge clk); #1;
      alu = $urandom;
      ExValid = 1'b1; ExRegWrite = 1'b1; ExRd = 5'd3; ExAluResult = alu;
      dmem.dmem_ack = 1'b1; dmem.dmem_rdata = $urandom;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         tests++;
         if (MemResult !== alu || MemRegWrite !== 1'b1 || MemRd !== 5'd3 || MemStall !== 1'b0 ||
             dmem.dmem_req !== 1'b0) begin
            fails++;
            $display("FAIL late ack %0d: result=%h rw=%b rd=%0d stall=%b req=%b, required %h 1 3 0 0",
                     i, MemResult, MemRegWrite, MemRd, MemStall, dmem.dmem_req, alu);
         end
         @(posedge clk); #1;
         dmem.dmem_ack = 1'b0;
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_alu_passthrough();
      test_directed_mem();
      test_misalign();
      test_random_mem();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM pipeline stage between the EX/MEM register and the MEM/WB register. It passes ALU results straight through for non-memory instructions. Loads and stores become a req/ack transaction on the data-memory port, with byte-lane steering, sign/zero extension, a misalignment check and a bus timeout. While a transaction is in flight it raises MemStall to freeze the upstream pipeline registers, then presents MemResult/MemRegWrite/MemRd to MEM/WB for exactly one cycle.

Parameters:
TIMEOUT, 16, max cycles BUSY waits for dmem_ack before aborting (>=2)
CNT_W, 5, width of timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
ExValid  in  1  EX/MEM holds a live instruction
ExAluResult  in  32  ALU result / effective address
ExStoreData  in  32  rs2 value for stores
ExMemRead  in  1  load
ExMemWrite  in  1  store
ExFunct3  in  3  access size/sign (RV32I encoding)
ExRegWrite  in  1  instruction writes rd
ExRd  in  5  destination register
MemResult  out  32  to MEM/WB
MemRegWrite  out  1  to MEM/WB
MemRd  out  5  to MEM/WB
MemStall  out  1  to hazard unit: hold PC, IF/ID, ID/EX, EX/MEM, MEM/WB
MemMisalign  out  1  one-cycle pulse: misaligned or illegal-size access
MemBusErr  out  1  one-cycle pulse: timeout abort
dmem_req  out  1  registered request, held until ack
dmem_we  out  1  write
dmem_addr  out  32  word address {addr[31:2],2'b00}
dmem_wdata  out  32  lane-replicated store data
dmem_wstrb  out  4  byte enables (0000 on reads)
dmem_ack  in  1  one-cycle completion strobe
dmem_rdata  in  32  read word, valid when dmem_ack=1

Behaviour:
- Reset (rst=0, async): state=IDLE, counter=0, all captured registers 0, dmem_req/dmem_we=0, dmem_wstrb=0, MemStall/MemMisalign/MemBusErr=0.
- States: IDLE, BUSY, DONE.
- IDLE, no memory op (ExValid=0 or neither ExMemRead nor ExMemWrite):
  - Combinational passthrough: MemResult=ExAluResult, MemRegWrite=ExRegWrite&ExValid, MemRd=ExRd.
  - MemStall=0.
- IDLE, memory op, aligned and legal:
  - Capture addr, steered wdata/wstrb, funct3, RegWrite, Rd and we.
  - MemStall=1 combinationally this cycle; MemRegWrite=0.
  - Next state BUSY; dmem_req=1 from the next cycle.
- Legality:
  - LB/LBU/SB: any address.
  - LH/LHU/SH: addr[0]=0.
  - LW/SW: addr[1:0]=0.
  - Load funct3 must be one of 000, 001, 010, 100, 101. Store funct3 must be one of 000, 001, 010.
  - ExMemRead&ExMemWrite both set is illegal.
- IDLE, illegal access: MemMisalign=1 for that cycle, MemRegWrite=0, no request, no stall; state stays IDLE.
- Store steering:
  - SB: wdata={4{b}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{h}}, wstrb=0011<<addr[1:0].
  - SW: wstrb=1111.
- BUSY:
  - dmem_req held 1 with stable addr/we/wdata/wstrb; MemStall=1; counter increments each cycle.
  - On dmem_ack: latch extracted load data into result register. Byte/half is selected by addr[1:0], sign-extended for LB/LH, zero-extended for LBU/LHU. Stores latch 0.
  - dmem_req deasserts the cycle after ack. Next state DONE.
  - If counter reaches TIMEOUT-1 without ack: abort, dmem_req deasserts, MemBusErr pulses one cycle, captured RegWrite forced 0. Next state DONE.
  - Ack in the same cycle as timeout: ack wins, no error.
- DONE (exactly one cycle):
  - MemStall=0.
  - MemResult=result register; MemRegWrite=captured RegWrite (0 for stores and aborts); MemRd=captured Rd.
  - EX/MEM inputs are ignored this cycle. Next state IDLE.
  - Back-to-back memory ops therefore cost at least 3 cycles each.
- dmem_ack outside BUSY is ignored.
- Counter clears on entry to BUSY.
- Reset mid-transaction aborts immediately: no result is written, dmem_req drops asynchronously.

Test Plan:
- ALU op: ExValid=1, ExRegWrite=1, ExRd=5, ExAluResult=0x1234 -> same cycle MemResult=0x1234, MemRegWrite=1, MemRd=5, MemStall=0, dmem_req=0.
- LB at 0x103, memory ack after 2 BUSY cycles with rdata=0x80AABBCC -> MemStall high 3 cycles; DONE gives MemResult=0xFFFFFF80, MemRegWrite=1. Repeat with LBU -> 0x00000080.
- SH at 0x22, ExStoreData=0xDEAD1234 -> dmem_we=1, dmem_addr=0x20, wdata=0x12341234, wstrb=1100; DONE MemRegWrite=0.
- LW at 0x6 -> MemMisalign pulses 1 cycle, no dmem_req, MemRegWrite=0, MemStall=0. Funct3=011 load -> same response.
- Load with ack never asserted, TIMEOUT=16 -> dmem_req high 16 cycles then drops, MemBusErr pulses once, DONE with MemRegWrite=0, then IDLE.
- rst pulled low during BUSY -> dmem_req, MemStall and all outputs go 0 immediately. After release, state is IDLE and a late dmem_ack is ignored.
